ahbl_splitter_n: RTL and testbench
==================================

Name: ahbl_splitter_n

Overview:
- Parametrised N-port AHB-Lite address-phase decoder and data-phase response multiplexer; sits between the AHB-Lite master bus and NS slaves.
- Page-based decode on the top PAGE_BITS of HADDR, with a per-slave page table.
- Built-in default slave returns the two-cycle AHB ERROR response for unmapped transfers.
- Bus watchdog terminates data phases stalled beyond TIMEOUT cycles with ERROR and records the offending slave.

Parameters:
- NS, 5: number of slave ports, 1..16.
- PAGE_BITS, 4: HADDR[31:32-PAGE_BITS] is the page index.
- PAGES, {4'h6,4'h5,4'h4,4'h2,4'h0}: packed NS*PAGE_BITS page table; slave i owns page PAGES[i*PAGE_BITS +: PAGE_BITS].
- TIMEOUT, 255: stall cycles before watchdog abort; 0 disables the watchdog.
- BAD_DATA, 32'hBADDBEEF: HRDATA value when no slave owns the data phase.

Ports:
- HCLK  in  1  bus clock.
- HRESET  in  1  asynchronous, active-high reset.
- HADDR  in  32  master address.
- HTRANS  in  2  master transfer type.
- HREADY  out  1  bus ready, fed back to the master and all slaves.
- HRDATA  out  32  read data to the master.
- HRESP  out  1  response to the master; 1 = ERROR.
- S_HSEL  out  NS  one-hot (or zero) slave selects.
- S_HRDATA  in  NS*32  slave read data; slice i belongs to slave i.
- S_HREADYOUT  in  NS  per-slave ready.
- S_HRESP  in  NS  per-slave response.
- TO_FLAG  out  1  sticky watchdog-abort flag.
- TO_SLAVE  out  4  index of the slave that timed out.
- TO_CLR  in  1  synchronous clear for TO_FLAG and TO_SLAVE.

Behaviour:
- Decode is combinational from HADDR only.
- S_HSEL[i] = 1 when the page index equals slave i's PAGES entry; if several entries match, only the lowest index is asserted.
- If no entry matches, internal unmapped = 1.
- Data-phase owner register sel_d (NS+1 bits, one-hot plus default slave):
  - Loads the decode result on each cycle where HREADY = 1, including IDLE/BUSY transfers.
  - An IDLE/BUSY transfer to an unmapped page loads zero (no owner).
  - An IDLE/BUSY transfer to a mapped page loads that slave; the slave itself returns zero-wait OKAY.
  - Reset value 0.
- Response mux, when the owner is slave i and the watchdog is not active:
  - HREADY = S_HREADYOUT[i], HRESP = S_HRESP[i], HRDATA = slice i.
- With no owner: HREADY = 1, HRESP = 0, HRDATA = BAD_DATA.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE -> DS_ERR1 when HREADY & HTRANS[1] & unmapped.
  - DS_ERR1 drives HREADY = 0, HRESP = 1, then -> DS_ERR2.
  - DS_ERR2 drives HREADY = 1, HRESP = 1, then -> DS_IDLE, or -> DS_ERR1 if another unmapped NONSEQ/SEQ is sampled in this cycle.
  - HRDATA = BAD_DATA in both ERR states.
- Watchdog (TIMEOUT > 0):
  - wd_cnt (8 bits, saturating) increments each cycle the owner is a real slave and HREADY = 0.
  - wd_cnt clears whenever HREADY = 1.
  - When wd_cnt == TIMEOUT-1 with HREADY still 0, the watchdog FSM enters WD_ERR1 and drives HREADY = 0, HRESP = 1, overriding the slave.
  - WD_ERR1 -> WD_ERR2 drives HREADY = 1, HRESP = 1, then returns to WD_IDLE.
  - On entering WD_ERR1: TO_FLAG <= 1 and TO_SLAVE <= owner index.
  - During WD_ERR1/2, slave HREADYOUT/HRESP are ignored.
  - TO_CLR clears the flag unless a new abort occurs in the same cycle; the new abort wins.
- Reset values:
  - sel_d = 0, both FSMs in IDLE, wd_cnt = 0, TO_FLAG = 0, TO_SLAVE = 0.
  - Therefore HREADY = 1, HRESP = 0, HRDATA = BAD_DATA.
  - Reset asserted mid-transfer returns all state to these values immediately (asynchronous).
- Latency:
  - Selects are zero-cycle, in the same cycle as the address.
  - Response muxing is combinational from sel_d; there is no added wait state for mapped slaves.

Test Plan:
- Reset, then IDLE: HREADY = 1, HRESP = 0, HRDATA = 32'hBADDBEEF, S_HSEL = 0, TO_FLAG = 0.
- NONSEQ read 0x4000_0010, slave 2 returns HREADYOUT = 1 and data 0x1234_5678:
  - S_HSEL = 5'b00100 in the address cycle.
  - Next cycle HRDATA = 0x1234_5678, HREADY = 1, HRESP = 0.
- NONSEQ read 0xF000_0000 (unmapped):
  - Data phase gives HREADY = 0/HRESP = 1, then HREADY = 1/HRESP = 1.
  - A following NONSEQ to 0x0000_0000 is accepted on the second ERROR cycle and completes OKAY.
- Back-to-back transfers: slave 1 with 2 wait states, then slave 3 zero-wait:
  - HREADY follows S_HREADYOUT[1] (0,0,1), then S_HREADYOUT[3].
  - sel_d does not change during the wait states.
- Slave 4 holds HREADYOUT = 0 with TIMEOUT = 8:
  - After 8 stall cycles, ERROR two-cycle response is issued.
  - TO_FLAG = 1, TO_SLAVE = 4.
  - TO_CLR pulse clears both.
- Page 0x6 entries duplicated in slots 3 and 4: only S_HSEL[3] asserts. Separately, HRESET asserted during a DS_ERR1 cycle: outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ahbl_splitter_n.sv
// AHB-Lite N-port splitter: page-table address decode, data-phase response mux,
// built-in ERROR default slave and a stall watchdog that aborts hung data phases.
module ahbl_splitter_n #(
    parameter int                          NS        = 5,
    parameter int                          PAGE_BITS = 4,
    parameter logic [NS*PAGE_BITS-1:0]     PAGES     = {4'h6, 4'h5, 4'h4, 4'h2, 4'h0},
    parameter int                          TIMEOUT   = 255,
    parameter logic [31:0]                 BAD_DATA  = 32'hBADDBEEF
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [31:0]          HADDR,
    input  logic [1:0]           HTRANS,
    output logic                 HREADY,
    output logic [31:0]          HRDATA,
    output logic                 HRESP,
    output logic [NS-1:0]        S_HSEL,
    input  logic [NS*32-1:0]     S_HRDATA,
    input  logic [NS-1:0]        S_HREADYOUT,
    input  logic [NS-1:0]        S_HRESP,
    output logic                 TO_FLAG,
    output logic [3:0]           TO_SLAVE,
    input  logic                 TO_CLR
);

    localparam logic [1:0] DS_IDLE = 2'd0;
    localparam logic [1:0] DS_ERR1 = 2'd1;
    localparam logic [1:0] DS_ERR2 = 2'd2;

    localparam logic [1:0] WD_IDLE = 2'd0;
    localparam logic [1:0] WD_ERR1 = 2'd1;
    localparam logic [1:0] WD_ERR2 = 2'd2;

    localparam logic [7:0] WD_LIMIT = 8'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [PAGE_BITS-1:0] page;
    logic [NS-1:0]        dec;
    logic                 unmapped;
    logic [NS:0]          sel_d;
    logic                 owner_real;
    logic [3:0]           owner_idx;
    logic                 sl_ready;
    logic                 sl_resp;
    logic [31:0]          sl_data;
    logic [1:0]           ds_state;
    logic [1:0]           ds_next;
    logic [1:0]           wd_state;
    logic [1:0]           wd_next;
    logic [7:0]           wd_cnt;
    logic                 ds_accept;
    logic                 wd_fire;
    logic                 unused_bits;

    assign page = HADDR[31 -: PAGE_BITS];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    // Walking from the top index down lets the lowest matching slave win on duplicate pages.
    always_comb begin
        dec = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (page == PAGES[i*PAGE_BITS +: PAGE_BITS]) begin
                dec    = '0;
                dec[i] = 1'b1;
            end
        end
    end

    assign unmapped = ~|dec;
    assign S_HSEL   = dec;

    always_comb begin
        owner_idx = '0;
        sl_ready  = 1'b1;
        sl_resp   = 1'b0;
        sl_data   = BAD_DATA;
        for (int i = 0; i < NS; i++) begin
            if (sel_d[i]) begin
                owner_idx = 4'(i);
                sl_ready  = S_HREADYOUT[i];
                sl_resp   = S_HRESP[i];
                sl_data   = S_HRDATA[i*32 +: 32];
            end
        end
    end

    assign owner_real = |sel_d[NS-1:0];

    // Watchdog and default-slave responses take priority over the owning slave.
    always_comb begin
        if (wd_state != WD_IDLE) begin
            HREADY = (wd_state == WD_ERR2);
            HRESP  = 1'b1;
            HRDATA = BAD_DATA;
        end else if (ds_state != DS_IDLE) begin
            HREADY = (ds_state == DS_ERR2);
            HRESP  = 1'b1;
            HRDATA = BAD_DATA;
        end else begin
            HREADY = sl_ready;
            HRESP  = sl_resp;
            HRDATA = sl_data;
        end
    end

    assign ds_accept = HREADY & HTRANS[1] & unmapped;
    assign wd_fire   = (TIMEOUT > 0) && (wd_state == WD_IDLE) && owner_real &&
                       !HREADY && (wd_cnt == WD_LIMIT);

    always_comb begin
        ds_next = DS_IDLE;
        case (ds_state)
            DS_IDLE: ds_next = ds_accept ? DS_ERR1 : DS_IDLE;
            DS_ERR1: ds_next = DS_ERR2;
            DS_ERR2: ds_next = ds_accept ? DS_ERR1 : DS_IDLE;
            default: ds_next = DS_IDLE;
        endcase
    end

    always_comb begin
        wd_next = WD_IDLE;
        case (wd_state)
            WD_IDLE: wd_next = wd_fire ? WD_ERR1 : WD_IDLE;
            WD_ERR1: wd_next = WD_ERR2;
            default: wd_next = WD_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_d    <= '0;
            ds_state <= DS_IDLE;
            wd_state <= WD_IDLE;
            wd_cnt   <= '0;
            TO_FLAG  <= 1'b0;
            TO_SLAVE <= '0;
        end else begin
            ds_state <= ds_next;
            wd_state <= wd_next;
            // An unmapped IDLE/BUSY leaves no owner; an unmapped NONSEQ/SEQ goes to the default slave.
            if (HREADY) begin
                sel_d <= unmapped ? {HTRANS[1], {NS{1'b0}}} : {1'b0, dec};
            end
            if (HREADY) begin
                wd_cnt <= '0;
            end else if (owner_real && wd_cnt != 8'hFF) begin
                wd_cnt <= wd_cnt + 8'd1;
            end
            if (wd_fire) begin
                TO_FLAG  <= 1'b1;
                TO_SLAVE <= owner_idx;
            end else if (TO_CLR) begin
                TO_FLAG  <= 1'b0;
                TO_SLAVE <= '0;
            end
        end
    end

    assign unused_bits = ^{HADDR[31-PAGE_BITS:0], HTRANS[0], sel_d[NS]};

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// Self-checking bench for ahbl_splitter_n: scoreboarded read data phases plus
// directed checks of wait states, default-slave ERROR, watchdog abort and reset.
module tb_ahbl_splitter_n;

    localparam int          NS  = 5;
    localparam logic [31:0] BAD = 32'hBADDBEEF;

    logic              HCLK;
    logic              HRESET;
    logic [31:0]       HADDR;
    logic [1:0]        HTRANS;
    logic              HREADY;
    logic [31:0]       HRDATA;
    logic              HRESP;
    logic [NS-1:0]     S_HSEL;
    logic [NS*32-1:0]  S_HRDATA;
    logic [NS-1:0]     S_HREADYOUT;
    logic [NS-1:0]     S_HRESP;
    logic              TO_FLAG;
    logic [3:0]        TO_SLAVE;
    logic              TO_CLR;

    logic              d_hready;
    logic [31:0]       d_hrdata;
    logic              d_hresp;
    logic [NS-1:0]     d_hsel;
    logic              d_to_flag;
    logic [3:0]        d_to_slave;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        resp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    ahbl_splitter_n #(.NS(NS), .PAGE_BITS(4), .PAGES({4'h6, 4'h5, 4'h4, 4'h2, 4'h0}),
                      .TIMEOUT(8), .BAD_DATA(BAD)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .S_HSEL(S_HSEL),
        .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
        .TO_FLAG(TO_FLAG), .TO_SLAVE(TO_SLAVE), .TO_CLR(TO_CLR)
    );

    // Duplicate page 0x6 in slots 3 and 4 to exercise lowest-index priority.
    ahbl_splitter_n #(.NS(NS), .PAGE_BITS(4), .PAGES({4'h6, 4'h6, 4'h4, 4'h2, 4'h0}),
                      .TIMEOUT(8), .BAD_DATA(BAD)) dut_dup (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
        .HREADY(d_hready), .HRDATA(d_hrdata), .HRESP(d_hresp), .S_HSEL(d_hsel),
        .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
        .TO_FLAG(d_to_flag), .TO_SLAVE(d_to_slave), .TO_CLR(TO_CLR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic mid();
        @(negedge HCLK);
    endtask

    task automatic drive(input logic [31:0] addr, input logic [1:0] trans);
        HADDR  = addr;
        HTRANS = trans;
    endtask

    task automatic set_data(input int idx, input logic [31:0] val);
        S_HRDATA[idx*32 +: 32] = val;
    endtask

    task automatic push(input string tag, input logic [31:0] data, input logic resp);
        exp_t e;
        e.tag  = tag;
        e.data = data;
        e.resp = resp;
        sb.push_back(e);
    endtask

    // Called in a data-phase cycle where HREADY=1: retire the oldest expected transfer.
    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_depth", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_data"}, HRDATA, e.data);
            check({e.tag, "_resp"}, 32'(HRESP), 32'(e.resp));
        end
    endtask

    initial begin
        int stalls;
        HRESET      = 1'b1;
        TO_CLR      = 1'b0;
        S_HREADYOUT = '1;
        S_HRESP     = '0;
        drive(32'hF000_0000, 2'b00);
        set_data(0, 32'h0000_5A5A);
        set_data(1, 32'h1111_0001);
        set_data(2, 32'h2222_0002);
        set_data(3, 32'h3333_0003);
        set_data(4, 32'h4444_0004);

        mid();
        check("rst_hready", 32'(HREADY), 32'd1);
        check("rst_hrdata", HRDATA, BAD);
        tick();
        HRESET = 1'b0;

        // Idle after reset
        mid();
        check("idle_hready", 32'(HREADY), 32'd1);
        check("idle_hresp", 32'(HRESP), 32'd0);
        check("idle_hrdata", HRDATA, BAD);
        check("idle_hsel", 32'(S_HSEL), 32'd0);
        check("idle_toflag", 32'(TO_FLAG), 32'd0);
        tick();

        // Zero-wait read from slave 2
        drive(32'h4000_0010, 2'b10);
        mid();
        check("s2_hsel", 32'(S_HSEL), 32'b00100);
        push("rd_s2", 32'h1234_5678, 1'b0);
        tick();
        drive(32'hF000_0000, 2'b00);
        set_data(2, 32'h1234_5678);
        mid();
        check("s2_hready", 32'(HREADY), 32'd1);
        pop_check();
        tick();

        // Unmapped NONSEQ, then NONSEQ to slave 0 accepted on second ERROR cycle
        drive(32'hF000_0000, 2'b10);
        mid();
        check("unm_hsel", 32'(S_HSEL), 32'd0);
        push("unmapped", BAD, 1'b1);
        tick();
        drive(32'h0000_0000, 2'b10);
        mid();
        check("err1_hready", 32'(HREADY), 32'd0);
        check("err1_hresp", 32'(HRESP), 32'd1);
        check("err1_hrdata", HRDATA, BAD);
        tick();
        mid();
        check("err2_hready", 32'(HREADY), 32'd1);
        pop_check();
        check("s0_hsel", 32'(S_HSEL), 32'b00001);
        push("rd_s0", 32'h0000_5A5A, 1'b0);
        tick();
        drive(32'hF000_0000, 2'b00);
        mid();
        check("s0_hready", 32'(HREADY), 32'd1);
        pop_check();
        tick();

        // Slave 1 with two wait states, then slave 3 zero-wait
        drive(32'h2000_0100, 2'b10);
        mid();
        check("s1_hsel", 32'(S_HSEL), 32'b00010);
        push("rd_s1", 32'h1111_0001, 1'b0);
        tick();
        drive(32'h5000_0000, 2'b10);
        S_HREADYOUT[1] = 1'b0;
        for (int w = 0; w < 2; w++) begin
            mid();
            check($sformatf("s1_ws%0d_hready", w), 32'(HREADY), 32'd0);
            check($sformatf("s1_ws%0d_owner", w), HRDATA, 32'h1111_0001);
            tick();
        end
        S_HREADYOUT[1] = 1'b1;
        mid();
        check("s1_hready", 32'(HREADY), 32'd1);
        pop_check();
        check("s3_hsel", 32'(S_HSEL), 32'b01000);
        push("rd_s3", 32'h3333_0003, 1'b0);
        tick();
        drive(32'hF000_0000, 2'b00);
        mid();
        check("s3_hready", 32'(HREADY), 32'd1);
        pop_check();
        tick();

        // Slave 4 hangs: watchdog aborts after 8 stall cycles
        drive(32'h6000_0000, 2'b10);
        mid();
        check("s4_hsel", 32'(S_HSEL), 32'b10000);
        check("dup_hsel", 32'(d_hsel), 32'b01000);
        push("to_s4", BAD, 1'b1);
        tick();
        drive(32'hF000_0000, 2'b00);
        S_HREADYOUT[4] = 1'b0;
        stalls = 0;
        for (int n = 0; n < 40; n++) begin
            mid();
            if (HRESP) break;
            stalls++;
            tick();
        end
        check("wd_stalls", 32'(stalls), 32'd8);
        check("wd_err1_hready", 32'(HREADY), 32'd0);
        check("wd_err1_hresp", 32'(HRESP), 32'd1);
        check("wd_flag", 32'(TO_FLAG), 32'd1);
        check("wd_slave", 32'(TO_SLAVE), 32'd4);
        tick();
        mid();
        check("wd_err2_hready", 32'(HREADY), 32'd1);
        pop_check();
        tick();
        S_HREADYOUT[4] = 1'b1;
        mid();
        check("wd_flag_sticky", 32'(TO_FLAG), 32'd1);
        check("wd_after_hresp", 32'(HRESP), 32'd0);
        TO_CLR = 1'b1;
        tick();
        TO_CLR = 1'b0;
        mid();
        check("clr_flag", 32'(TO_FLAG), 32'd0);
        check("clr_slave", 32'(TO_SLAVE), 32'd0);
        tick();

        // Asynchronous reset during DS_ERR1
        drive(32'hF000_0000, 2'b10);
        tick();
        drive(32'hF000_0000, 2'b00);
        mid();
        check("ar_err1_hready", 32'(HREADY), 32'd0);
        #1 HRESET = 1'b1;
        #1;
        check("ar_hready", 32'(HREADY), 32'd1);
        check("ar_hresp", 32'(HRESP), 32'd0);
        check("ar_hrdata", HRDATA, BAD);
        check("ar_toflag", 32'(TO_FLAG), 32'd0);
        tick();
        HRESET = 1'b0;
        mid();
        check("ar_post_hready", 32'(HREADY), 32'd1);

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
